// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage:
// access size codes, FSM states and byte-lane helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Byte-lane enables for a store of the given size at offset lo.
    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Illegal size or an address not aligned to the access size.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b0;
        unique case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ram_be_sp.sv
// Single-port RAM, synchronous read, four byte-enabled lanes.
// A read in the same cycle as a write returns the old word.
module ram_be_sp #(
    parameter int WORD_ADDR_W = 6,
    parameter int INIT_ZERO   = 1
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [3:0]             be,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata
);

    localparam int DEPTH = 2 ** WORD_ADDR_W;

    if (INIT_ZERO != 0) begin : g_zero
        logic [31:0] mem [DEPTH] = '{default: '0};

        // Lane-masked write and registered read of the old word.
        always_ff @(posedge clk) begin
            for (int i = 0; i < 4; i++) begin
                if (we && be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end else begin : g_undef
        logic [31:0] mem [DEPTH];

        // Lane-masked write and registered read of the old word.
        always_ff @(posedge clk) begin
            for (int i = 0; i < 4; i++) begin
                if (we && be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_lsu_ctrl.sv
// Load/store controller around a byte-enabled RAM, with
// sign/zero-extended loads and an LED view of the last word.
module ram_lsu_ctrl
    import mem_pkg::*;
#(
    parameter int WORD_ADDR_W = 6,
    parameter int INIT_ZERO   = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Req,
    input  logic                   Mem_Write,
    input  logic [1:0]             Size,
    input  logic                   Sign_Ext,
    input  logic [WORD_ADDR_W+1:0] Addr,
    input  logic [31:0]            W_Data,
    input  logic [1:0]             LED_Sel,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Misalign,
    output logic [31:0]            R_Data,
    output logic [7:0]             LED
);

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        req_mis;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  lo_q;
    logic        mis_q;
    logic [31:0] last_word;
    logic [31:0] r_data_q;
    logic [7:0]  led_q;
    logic [31:0] load_val;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign req_mis = misaligned(Size, Addr[1:0]);
    assign ram_be  = byte_en(Size, Addr[1:0]);

    // Replicate store data so every enabled lane sees its bytes.
    always_comb begin
        ram_wdata = W_Data;
        unique case (Size)
            SZ_BYTE: ram_wdata = {4{W_Data[7:0]}};
            SZ_HALF: ram_wdata = {2{W_Data[15:0]}};
            default: ram_wdata = W_Data;
        endcase
    end

    ram_be_sp #(
        .WORD_ADDR_W (WORD_ADDR_W),
        .INIT_ZERO   (INIT_ZERO)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (Addr[WORD_ADDR_W+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State register; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept strobe and RAM write strobe.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ram_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Req && !Rst) begin
                    accept = 1'b1;
                    if (req_mis) begin
                        state_d = S_DONE;
                    end else if (Mem_Write) begin
                        ram_we  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Capture the request attributes needed after acceptance.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            size_q <= SZ_BYTE;
            sext_q <= 1'b0;
            lo_q   <= 2'b00;
            mis_q  <= 1'b0;
        end else if (accept) begin
            size_q <= Size;
            sext_q <= Sign_Ext;
            lo_q   <= Addr[1:0];
            mis_q  <= req_mis;
        end
    end

    assign lane_b = ram_rdata[8*lo_q +: 8];
    assign lane_h = ram_rdata[16*lo_q[1] +: 16];

    // Select the addressed lane and extend it.
    always_comb begin
        load_val = ram_rdata;
        unique case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & lane_b[7]}}, lane_b};
            SZ_HALF: load_val = {{16{sext_q & lane_h[15]}}, lane_h};
            default: load_val = ram_rdata;
        endcase
    end

    // Latch raw word and extended result when read data is valid.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_word <= '0;
            r_data_q  <= '0;
        end else if (state_q == S_RD_WAIT) begin
            last_word <= ram_rdata;
            r_data_q  <= load_val;
        end
    end

    // LED shows the selected byte of the last fetched word.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            led_q <= '0;
        end else begin
            led_q <= last_word[8*LED_Sel +: 8];
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_DONE);
    assign Misalign = Done & mis_q;
    assign R_Data   = r_data_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_ram_lsu_ctrl.sv
// Self-checking bench for ram_lsu_ctrl against a byte-array
// reference model of memory, load result and LED.
module tb_ram_lsu_ctrl;

    localparam int WA = 6;
    localparam int NBYTES = 4 * (2 ** WA);

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Req = 1'b0;
    logic          Mem_Write = 1'b0;
    logic [1:0]    Size = 2'b00;
    logic          Sign_Ext = 1'b0;
    logic [WA+1:0] Addr = '0;
    logic [31:0]   W_Data = '0;
    logic [1:0]    LED_Sel = 2'b00;
    logic          Busy;
    logic          Done;
    logic          Misalign;
    logic [31:0]   R_Data;
    logic [7:0]    LED;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  m [NBYTES];
    logic [31:0] exp_r = '0;
    logic [31:0] exp_last = '0;

    always #5 Clk = ~Clk;

    ram_lsu_ctrl #(.WORD_ADDR_W(WA), .INIT_ZERO(1)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .Mem_Write (Mem_Write),
        .Size      (Size),
        .Sign_Ext  (Sign_Ext),
        .Addr      (Addr),
        .W_Data    (W_Data),
        .LED_Sel   (LED_Sel),
        .Busy      (Busy),
        .Done      (Done),
        .Misalign  (Misalign),
        .R_Data    (R_Data),
        .LED       (LED)
    );

    function automatic logic [7:0] led_of(input logic [31:0] w, input logic [1:0] s);
        return 8'((w >> (8 * s)) & 32'hFF);
    endfunction

    function automatic logic [31:0] word_at(input int a);
        int b;
        b = a - (a % 4);
        return {m[b+3], m[b+2], m[b+1], m[b]};
    endfunction

    // One complete access with latency, result and LED checks.
    task automatic run_access(input logic w, input logic [1:0] sz,
                              input logic se, input int a,
                              input logic [31:0] wd, input string nm);
        int nb;
        int lat;
        logic mis;
        logic [31:0] v;
        nb  = 1 << sz;
        mis = (sz == 2'b11) || ((a % nb) != 0);
        if (!mis && w) begin
            for (int i = 0; i < nb; i++) m[a+i] = wd[8*i +: 8];
        end
        if (!mis && !w) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (32'(m[a+i]) << (8 * i));
            if (se && nb == 1 && v[7]) v = v | 32'hFFFFFF00;
            if (se && nb == 2 && v[15]) v = v | 32'hFFFF0000;
            exp_r = v;
            exp_last = word_at(a);
        end
        lat = (mis || w) ? 1 : 2;
        @(negedge Clk);
        Req = 1'b1; Mem_Write = w; Size = sz; Sign_Ext = se;
        Addr = (WA+2)'(a); W_Data = wd;
        @(posedge Clk); #1;
        Req = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            n_checks++;
            if (Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy c%0d: got %b want 1", nm, k, Busy);
            end
            if (k < lat) begin
                n_checks++;
                if (Done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_done: got %b want 0", nm, Done);
                end
                @(posedge Clk); #1;
            end else begin
                n_checks++;
                if (Done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s done: got %b want 1", nm, Done);
                end
                n_checks++;
                if (Misalign !== mis) begin
                    n_fail++;
                    $display("FAIL %s misalign: got %b want %b", nm, Misalign, mis);
                end
                n_checks++;
                if (R_Data !== exp_r) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h want %h", nm, R_Data, exp_r);
                end
            end
        end
        @(posedge Clk); #1;
        n_checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after: busy=%b done=%b want 0 0", nm, Busy, Done);
        end
        n_checks++;
        if (LED !== led_of(exp_last, LED_Sel)) begin
            n_fail++;
            $display("FAIL %s led: got %h want %h", nm, LED, led_of(exp_last, LED_Sel));
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if ({Busy, Done, Misalign} !== 3'b000 || R_Data !== 32'h0 || LED !== 8'h0) begin
            n_fail++;
            $display("FAIL reset: got b%b d%b m%b r%h l%h want all 0",
                     Busy, Done, Misalign, R_Data, LED);
        end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_word();
        run_access(1'b1, 2'b10, 1'b0, 8, 32'h003CC381, "st_word");
        run_access(1'b0, 2'b10, 1'b0, 8, 32'h0, "ld_word");
        n_checks++;
        if (R_Data !== 32'h003CC381) begin
            n_fail++;
            $display("FAIL ld_word_const: got %h want 003cc381", R_Data);
        end
    endtask

    task automatic test_byte_ext();
        run_access(1'b0, 2'b00, 1'b1, 9, 32'h0, "ld_byte_sx");
        n_checks++;
        if (R_Data !== 32'hFFFFFFC3) begin
            n_fail++;
            $display("FAIL ld_byte_sx_const: got %h want ffffffc3", R_Data);
        end
        run_access(1'b0, 2'b00, 1'b0, 9, 32'h0, "ld_byte_zx");
        n_checks++;
        if (R_Data !== 32'h000000C3) begin
            n_fail++;
            $display("FAIL ld_byte_zx_const: got %h want 000000c3", R_Data);
        end
    endtask

    task automatic test_half_led();
        run_access(1'b1, 2'b01, 1'b0, 10, 32'h0000BEEF, "st_half");
        run_access(1'b0, 2'b10, 1'b0, 8, 32'h0, "ld_after_half");
        n_checks++;
        if (R_Data !== 32'hBEEFC381) begin
            n_fail++;
            $display("FAIL ld_after_half_const: got %h want beefc381", R_Data);
        end
        @(negedge Clk); LED_Sel = 2'd3;
        @(posedge Clk); #1;
        n_checks++;
        if (LED !== 8'hBE) begin
            n_fail++;
            $display("FAIL led_sel3: got %h want be", LED);
        end
        @(negedge Clk); LED_Sel = 2'd0;
        @(posedge Clk); #1;
        n_checks++;
        if (LED !== 8'h81) begin
            n_fail++;
            $display("FAIL led_sel0: got %h want 81", LED);
        end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 2'b10, 1'b0, 6, 32'hFFFFFFFF, "st_mis");
        run_access(1'b0, 2'b10, 1'b0, 4, 32'h0, "ld_after_mis");
        n_checks++;
        if (R_Data !== 32'h0) begin
            n_fail++;
            $display("FAIL ld_after_mis_const: got %h want 0", R_Data);
        end
        run_access(1'b0, 2'b11, 1'b1, 0, 32'h0, "ld_sz11");
        run_access(1'b0, 2'b01, 1'b0, 3, 32'h0, "ld_half_odd");
    endtask

    task automatic test_reset_mid();
        @(negedge Clk);
        Req = 1'b1; Mem_Write = 1'b0; Size = 2'b10; Sign_Ext = 1'b0;
        Addr = 8'h08; LED_Sel = 2'd3;
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b0; Rst = 1'b1;
        @(posedge Clk); #1;
        exp_r = 0; exp_last = 0;
        n_checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || R_Data !== 32'h0 || LED !== 8'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got d%b b%b r%h l%h want 0 0 0 0",
                     Done, Busy, R_Data, LED);
        end
        @(negedge Clk);
        Req = 1'b1; Mem_Write = 1'b1; Size = 2'b10;
        Addr = 8'h10; W_Data = 32'hDEADBEEF;
        @(posedge Clk); #1;
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_store_busy: got %b want 0", Busy);
        end
        @(negedge Clk);
        Req = 1'b0; Rst = 1'b0;
        run_access(1'b0, 2'b10, 1'b0, 8, 32'h0, "reload_after_rst");
        n_checks++;
        if (R_Data !== 32'hBEEFC381) begin
            n_fail++;
            $display("FAIL reload_const: got %h want beefc381", R_Data);
        end
        run_access(1'b0, 2'b10, 1'b0, 16, 32'h0, "rst_store_blocked");
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        Req = 1'b1; Mem_Write = 1'b1; Size = 2'b10;
        Addr = 8'h20; W_Data = 32'h11111111;
        @(posedge Clk); #1;
        for (int i = 0; i < 4; i++) m[32+i] = 8'h11;
        n_checks++;
        if (Done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done1: got %b want 1", Done);
        end
        @(negedge Clk);
        Addr = 8'h24; W_Data = 32'h22222222;
        @(posedge Clk); #1;
        n_checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got d%b b%b want 0 0", Done, Busy);
        end
        @(posedge Clk); #1;
        Req = 1'b0;
        for (int i = 0; i < 4; i++) m[36+i] = 8'h22;
        n_checks++;
        if (Done !== 1'b1 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done2: got d%b b%b want 1 1", Done, Busy);
        end
        @(posedge Clk); #1;
        run_access(1'b0, 2'b10, 1'b0, 32, 32'h0, "b2b_ld1");
        run_access(1'b0, 2'b10, 1'b0, 36, 32'h0, "b2b_ld2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic w;
            logic [1:0] sz;
            logic se;
            int a;
            logic [31:0] wd;
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            se = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a - (a % (1 << sz));
            wd = $urandom;
            @(negedge Clk);
            LED_Sel = 2'($urandom_range(0, 3));
            run_access(w, sz, se, a, wd, "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) m[i] = 8'h00;
        test_reset();
        test_word();
        test_byte_ext();
        test_half_led();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
